// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional two's-complement overflow output enabled by macro SERIAL_SUB_OVF_EN.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
   output logic             ovf,
`endif
   output logic             bout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               bit_d;
   logic               brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
   logic               a_msb_q, a_msb_d;
   logic               b_msb_q, b_msb_d;
   logic               ovf_q, ovf_d;
`endif

   // Next-state, datapath and registered-output decode.
   // The minuend register doubles as the result register: difference bits
   // enter at the MSB as operand bits leave at the LSB.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
      brw_nxt = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sr_d  = a;
               b_sr_d  = b;
               brw_d   = bin;
               cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
               a_msb_d = a[WIDTH-1];
               b_msb_d = b[WIDTH-1];
`endif
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d = {bit_d, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            brw_d  = brw_nxt;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               diff_d  = {bit_d, a_sr_q[WIDTH-1:1]};
               bout_d  = brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
               ovf_d   = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d == SHIFT);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign bout  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with an expected-result scoreboard.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         ready, busy, done, bout;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
      .ovf   (ovf),
`endif
      .bout  (bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      exp_t       e;
      logic [W:0] t;
      t      = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
      e.diff = t[W-1:0];
      e.bout = t[W];
      e.ovf  = (av[W-1] != bv[W-1]) && (t[W-1] != av[W-1]);
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("diff", 32'(diff), 32'(e.diff));
            chk("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // Drive a request, confirm acceptance, then scramble operands.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
      @(negedge clk);
      a = av; b = bv; bin = bi; start = 1'b1;
      chk("ready_before_accept", 32'(ready), 32'd1);
      @(posedge clk);
      sb_q.push_back(model(av, bv, bi));
      #1 chk("busy_after_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv; bin = ~bi;
   endtask

   // Walk the WIDTH shift edges checking done latency and held outputs.
   task automatic wait_done(input logic [W-1:0] prev_diff);
      for (int i = 1; i <= int'(W); i++) begin
         @(posedge clk);
         #1;
         if (i < int'(W)) begin
            chk("busy_in_shift", 32'(busy), 32'd1);
            chk("no_early_done", 32'(done), 32'd0);
            chk("diff_held_in_shift", 32'(diff), 32'(prev_diff));
         end else begin
            chk("done_at_latency", 32'(done), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd0);
            chk("ready_in_done", 32'(ready), 32'd0);
         end
      end
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("ready_after_done", 32'(ready), 32'd1);
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_diff",  32'(diff),  32'd0);
      chk("rst_bout",  32'(bout),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      start_op(8'h0F, 8'h01, 1'b0);
      wait_done(8'h00);
      repeat (3) @(posedge clk);
      #1 chk("diff_held_idle", 32'(diff), 32'h0E);

      start_op(8'h00, 8'h01, 1'b0);
      wait_done(8'h0E);
      start_op(8'hAA, 8'h55, 1'b1);
      wait_done(8'hFF);
      start_op(8'hFF, 8'hFF, 1'b1);
      wait_done(8'h54);
      start_op(8'h80, 8'h01, 1'b0);
      wait_done(8'hFF);
      start_op(8'h05, 8'h03, 1'b0);
      wait_done(8'h7F);

      // Start held high: second request during SHIFT ignored, next accepted after done.
      @(negedge clk);
      a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      sb_q.push_back(model(8'h10, 8'h01, 1'b0));
      @(negedge clk);
      a = 8'h00;
      repeat (W) @(posedge clk);
      #1 chk("b2b_done", 32'(done), 32'd1);
      @(posedge clk);
      #1 chk("b2b_idle_gap", 32'(ready), 32'd1);
      @(posedge clk);
      sb_q.push_back(model(8'h00, 8'h01, 1'b0));
      #1 chk("b2b_second_accept", 32'(busy), 32'd1);
      @(negedge clk);
      start = 1'b0;
      repeat (W) @(posedge clk);
      #1 chk("b2b_second_done", 32'(done), 32'd1);
      @(posedge clk);

      // Reset during SHIFT aborts the operation without a done pulse.
      start_op(8'h33, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_done",  32'(done),  32'd0);
      chk("abort_diff",  32'(diff),  32'd0);
      chk("abort_bout",  32'(bout),  32'd0);
      void'(sb_q.pop_back());
      @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(posedge clk);
      #1 chk("abort_no_done", 32'(done), 32'd0);
      start_op(8'h3C, 8'h0C, 1'b1);
      wait_done(8'h00);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first, with a single borrow flip-flop.
- Inverse-operation companion to the combinational ripple-carry adder.
- Gives the datapath a small-area subtract unit with a start/done handshake.
- Results are checked against the adder: a == diff + b + bin (mod 2^WIDTH).

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- bin  input  1  borrow-in; captured on the accepting edge
- ready  output  1  high in IDLE (start will be accepted)
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse; diff/bout valid
- diff  output  WIDTH  difference; held until the next completion
- bout  output  1  borrow-out (1 when a < b + bin, unsigned); held like diff

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, bit counter and borrow FF all cleared.
- States:
  - IDLE: ready=1. If start=1 at an edge: load a, b into shift registers, load borrow FF=bin, count=0, go to SHIFT. Otherwise stay.
  - SHIFT: busy=1, ready=0. Each edge:
    - d = a_sr[0] ^ b_sr[0] ^ brw
    - brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)
    - d shifts into the result register MSB side; a_sr and b_sr shift right; count++.
    - On the edge where count reaches WIDTH-1 (the WIDTH-th bit), go to DONE.
  - DONE: lasts exactly one cycle. diff = assembled result, bout = final borrow, done=1, ready=0, busy=0. Next edge goes to IDLE.
- Latency:
  - Edge E0 accepts start; SHIFT occupies edges E1..EWIDTH; done is high in the cycle after edge EWIDTH.
  - So done rises WIDTH edges after the accepting edge.
  - Next start can be accepted at edge EWIDTH+2 at the earliest.
- diff/bout update only on entry to DONE.
  - They keep their old values during SHIFT.
  - They keep their values after done falls until the next completion.
- start while busy or in DONE: ignored, with no effect on the operation in progress. start held high continuously gives back-to-back operations with one IDLE cycle between them.
- Operand changes after the accepting edge have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Wrap-around is reported through bout, never saturated.
- Reset asserted mid-SHIFT: aborts immediately to reset values. No done pulse for the aborted operation. Previous diff/bout are lost (cleared to 0).
- rst_n deassertion is assumed synchronous to clk externally; the block adds no synchroniser.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), treating operands as two's complement.
  - Computed on entry to DONE as: ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - Reset value 0; held like diff.
- Undefined:
  - Port ovf absent; no extra flops.
  - All other behaviour identical.

Test Plan:
- WIDTH=8, a=0x0F, b=0x01, bin=0, start pulse -> done exactly 8 edges after acceptance; diff=0x0E, bout=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around).
- a=0xAA, b=0x55, bin=1 -> diff=0x54, bout=0. a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1.
- Start accepted with a=0x10, b=0x01, then start=1 with a=0x00 during SHIFT -> the second request is ignored; diff=0x0F. With start held high, the next acceptance occurs in the IDLE cycle after done.
- rst_n low for one cycle at the 4th SHIFT edge -> all outputs 0 immediately, no done pulse; a new start afterwards completes normally.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1. a=0x05, b=0x03 -> diff=0x02, ovf=0.
